pwm_led_ctrl: RTL and testbench

PWM_LED_CTRL -- requirements
Module: pwm_led_ctrl

---
 rtl/pwm_led_pkg.sv | 36 +++
 rtl/pwm_led_ctrl_if.sv | 12 +
 rtl/pwm_led_chan.sv | 85 ++++++++
 rtl/pwm_led_ctrl.sv | 150 +++++++++++++++
 tb/tb_pwm_led_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg -- register map, CTRL field positions and the CTRL register
// type shared by the PWM LED controller and its channel sub-module.
package pwm_led_pkg;

    // Register addresses
    localparam logic [6:0] ADDR_ID       = 7'h00;
    localparam logic [6:0] ADDR_CTRL     = 7'h01;
    localparam logic [6:0] ADDR_RATE     = 7'h02;
    localparam logic [6:0] ADDR_TGT_BASE = 7'h10;
    localparam logic [6:0] ADDR_CUR_BASE = 7'h20;

    // CTRL bit positions
    localparam int CTRL_DIM_LSB  = 0;
    localparam int CTRL_DIM_MSB  = 3;
    localparam int CTRL_EN_BIT   = 8;
    localparam int CTRL_FADE_BIT = 9;

    localparam logic [3:0] DIM_RESET = 4'd4;

    typedef struct packed {
        logic       fade;
        logic       en;
        logic [3:0] dim;
    } ctrl_t;

    // Pack CTRL into its bus word; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_DIM_MSB:CTRL_DIM_LSB] = c.dim;
        w[CTRL_EN_BIT]               = c.en;
        w[CTRL_FADE_BIT]             = c.fade;
        return w;
    endfunction

endpackage

// File: rtl/pwm_led_ctrl_if.sv
// pwm_led_ctrl_if -- single-cycle register bus of the PWM LED controller.
// The master drives the write strobe, address and write data; the slave
// returns combinational read data for the current address.
interface pwm_led_ctrl_if;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;

    modport master (output we, output addr, output wdat, input rdat);
    modport slave  (input we, input addr, input wdat, output rdat);
endinterface

// File: rtl/pwm_led_chan.sv
// pwm_led_chan -- one PWM channel: target duty register, current (faded)
// duty, active duty latched at period boundaries, and the slot comparator.
module pwm_led_chan #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tgt_we,
    input  logic [PW-1:0] tgt_wdat,
    input  logic          fade_mode,
    input  logic          tick,
    input  logic          load,
    input  logic [PW-1:0] slot,
    output logic [PW-1:0] tgt,
    output logic [PW-1:0] cur,
    output logic          pwm,
    output logic          busy
);

    logic [PW-1:0] tgt_next;
    logic [PW-1:0] cur_next;
    logic [PW-1:0] act;

    // Next target; a write in the same cycle as a fade tick steers that step.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        tgt_next = tgt;
        if (tgt_we) begin
            tgt_next = tgt_wdat;
        end
    end

    // Next current duty: follow target directly, or step by one per tick when fading.
    always_comb begin
        cur_next = cur;
        if (!fade_mode) begin
            cur_next = tgt_next;
        end else if (tick) begin
            if (cur < tgt_next) begin
                cur_next = cur + 1'b1;
            end else if (cur > tgt_next) begin
                cur_next = cur - 1'b1;
            end
        end
    end

    // Target register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt <= '0;
        end else begin
            tgt <= tgt_next;
        end
    end

    // Current duty; also covers an abrupt fade-mode clear, which snaps to target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= '0;
        end else begin
            cur <= cur_next;
        end
    end

    // Active duty changes only at the period boundary so no period mixes duties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act <= '0;
        end else if (load) begin
            act <= cur_next;
        end
    end

    // Registered PWM drive: high while the slot index is below the active duty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (slot < act);
        end
    end

    assign busy = (cur != tgt);

endmodule

// File: rtl/pwm_led_ctrl.sv
// pwm_led_ctrl -- multi-channel PWM LED controller with global dimming and
// optional linear fading of each channel toward its target duty.
// Optional feature macro: PWM_LED_FADE_EN (fade logic, RATE register and
// CTRL fade bit). Without it RATE and the fade bit read 0 and current duty
// always equals target.
module pwm_led_ctrl
    import pwm_led_pkg::*;
#(
    parameter int          NCH       = 3,
    parameter int          PW        = 8,
    parameter logic [31:0] DESIGN_ID = 32'hB00F0002
) (
    input  logic           clk,
    input  logic           reset_n,
    pwm_led_ctrl_if.slave  bus,
    output logic [NCH-1:0] pwm,
    output logic           led_ena,
    output logic           busy
);

    localparam int CW = PW + 4;

    logic [CW-1:0]  cnt;
    logic           period_end;
    ctrl_t          ctrl;
    logic           ctrl_we;
    logic           tgt_page;
    logic           cur_page;
    logic           fade_mode;
    logic           tick;
    logic [15:0]    rate;
    logic [31:0]    rdat_c;
    logic [PW-1:0]  tgt_a  [NCH];
    logic [PW-1:0]  cur_a  [NCH];
    logic [NCH-1:0] busy_v;

    assign period_end = &cnt;
    assign ctrl_we    = bus.we && (bus.addr == ADDR_CTRL);
    assign tgt_page   = (bus.addr[6:4] == ADDR_TGT_BASE[6:4]);
    assign cur_page   = (bus.addr[6:4] == ADDR_CUR_BASE[6:4]);

    // Free-running period counter: low 4 bits dim phase, high PW bits PWM slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt <= cnt + CW'(1);
        end
    end

    // CTRL register: dimming level, global enable and fade mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl.dim  <= DIM_RESET;
            ctrl.en   <= 1'b1;
            ctrl.fade <= 1'b0;
        end else if (ctrl_we) begin
            ctrl.dim <= bus.wdat[CTRL_DIM_MSB:CTRL_DIM_LSB];
            ctrl.en  <= bus.wdat[CTRL_EN_BIT];
`ifdef PWM_LED_FADE_EN
            ctrl.fade <= bus.wdat[CTRL_FADE_BIT];
`endif
        end
    end

`ifdef PWM_LED_FADE_EN
    logic [15:0] presc;

    // RATE register: fade prescale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate <= '0;
        end else if (bus.we && (bus.addr == ADDR_RATE)) begin
            rate <= bus.wdat[15:0];
        end
    end

    // Prescaler: one tick every RATE+1 cycles; >= recovers if RATE shrinks below the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    assign tick      = (presc >= rate);
    assign fade_mode = ctrl.fade;
`else
    assign rate      = '0;
    assign tick      = 1'b0;
    assign fade_mode = 1'b0;
`endif

    // Global dimming gate, registered one cycle behind the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_ena <= 1'b0;
        end else begin
            led_ena <= (cnt[3:0] <= ctrl.dim) && ctrl.en;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_led_chan #(.PW(PW)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .tgt_we   (bus.we && tgt_page && (bus.addr[3:0] == 4'(i))),
            .tgt_wdat (bus.wdat[PW-1:0]),
            .fade_mode(fade_mode),
            .tick     (tick),
            .load     (period_end),
            .slot     (cnt[CW-1:4]),
            .tgt      (tgt_a[i]),
            .cur      (cur_a[i]),
            .pwm      (pwm[i]),
            .busy     (busy_v[i])
        );
    end

    assign busy = |busy_v;

    // Read mux; unmapped and out-of-range channel addresses return zero.
    always_comb begin
        rdat_c = '0;
        if (bus.addr == ADDR_ID) begin
            rdat_c = DESIGN_ID;
        end else if (bus.addr == ADDR_CTRL) begin
            rdat_c = ctrl_word(ctrl);
        end else if (bus.addr == ADDR_RATE) begin
            rdat_c = {16'd0, rate};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(bus.addr[3:0]) == i) begin
                    if (tgt_page) begin
                        rdat_c = 32'(tgt_a[i]);
                    end else if (cur_page) begin
                        rdat_c = 32'(cur_a[i]);
                    end
                end
            end
        end
    end

    assign bus.rdat = rdat_c;

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// tb_pwm_led_ctrl -- directed self-checking bench for pwm_led_ctrl
// (NCH=3, PW=8). Fade checks apply when PWM_LED_FADE_EN is defined;
// otherwise the disabled-feature behaviour is checked instead.
module tb_pwm_led_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] pwm;
    logic       led_ena;
    logic       busy;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tally_pwm0  = 0;
    int tally_pwm12 = 0;
    int tally_led   = 0;

    pwm_led_ctrl_if bus_if ();

    pwm_led_ctrl #(
        .NCH      (3),
        .PW       (8),
        .DESIGN_ID(32'hB00F0002)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if.slave),
        .pwm    (pwm),
        .led_ena(led_ena),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; cyc == k means edge k has happened.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Running high-cycle tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (pwm[0])           tally_pwm0++;
        if (pwm[1] || pwm[2]) tally_pwm12++;
        if (led_ena)          tally_led++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.we   = 1'b1;
        bus_if.addr = a;
        bus_if.wdat = d;
        @(negedge clk);
        bus_if.we   = 1'b0;
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        #1;
        check(tag, bus_if.rdat, exp);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
        #1;
    endtask

    int s_p0, s_p12, s_led, c, b, v, prev, last, nsteps, idx;
    bit done;

    initial begin
        reset_n     = 1'b0;
        bus_if.we   = 1'b0;
        bus_if.addr = '0;
        bus_if.wdat = '0;
        repeat (3) @(negedge clk);

        // Reset state
        rd_check("id_reset", 7'h00, 32'hB00F0002);
        rd_check("ctrl_reset", 7'h01, 32'h104);
        rd_check("rate_reset", 7'h02, 32'h0);
        check("pwm_reset", 32'(pwm), 32'h0);
        check("led_reset", 32'(led_ena), 32'h0);
        check("busy_reset", 32'(busy), 32'h0);

        // Release between edges: cnt starts at 0 on the next edge
        @(negedge clk);
        #2 reset_n = 1'b1;
        s_p0  = tally_pwm0;
        s_led = tally_led;

        // Duty 0x80, fade off: first period still at duty 0
        do_write(7'h10, 32'h80);
        rd_check("tgt0_rd", 7'h10, 32'h80);
        rd_check("cur0_follow", 7'h20, 32'h80);
        wait_cyc(4096);
        check("pwm0_first_period", 32'(tally_pwm0 - s_p0), 32'd0);
        check("led_dim4_period", 32'(tally_led - s_led), 32'd1280);
        s_p0  = tally_pwm0;
        s_p12 = tally_pwm12;
        wait_cyc(4097);
        check("pwm0_boundary_high", 32'(pwm[0]), 32'h1);
        wait_cyc(8192);
        check("pwm0_duty80_highs", 32'(tally_pwm0 - s_p0), 32'd2048);
        check("pwm12_idle", 32'(tally_pwm12 - s_p12), 32'd0);

        // Global dimming
        do_write(7'h01, 32'h100);
        rd_check("ctrl_dim0_rd", 7'h01, 32'h100);
        c = cyc; s_led = tally_led; wait_cyc(c + 64);
        check("led_dim0", 32'(tally_led - s_led), 32'd4);
        do_write(7'h01, 32'h10F);
        c = cyc; s_led = tally_led; wait_cyc(c + 64);
        check("led_dim15", 32'(tally_led - s_led), 32'd64);
        do_write(7'h01, 32'h00F);
        c = cyc; s_led = tally_led; wait_cyc(c + 64);
        check("led_disabled", 32'(tally_led - s_led), 32'd0);
        do_write(7'h01, 32'h104);

        // Duty extremes over one aligned period
        do_write(7'h10, 32'hFF);
        c = cyc; b = (c / 4096 + 1) * 4096;
        wait_cyc(b); s_p0 = tally_pwm0; wait_cyc(b + 4096);
        check("pwm0_dutyFF", 32'(tally_pwm0 - s_p0), 32'd4080);
        do_write(7'h10, 32'h00);
        c = cyc; b = (c / 4096 + 1) * 4096;
        wait_cyc(b); s_p0 = tally_pwm0; wait_cyc(b + 4096);
        check("pwm0_duty0", 32'(tally_pwm0 - s_p0), 32'd0);

`ifdef PWM_LED_FADE_EN
        // Fade up to 5 at RATE=9
        do_write(7'h02, 32'd9);
        do_write(7'h01, 32'h304);
        rd_check("rate_rd", 7'h02, 32'd9);
        rd_check("ctrl_fade_rd", 7'h01, 32'h304);
        do_write(7'h11, 32'h05);
        check("busy_fade_start", 32'(busy), 32'h1);
        bus_if.addr = 7'h21;
        prev = 0; last = cyc; nsteps = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            v = int'(bus_if.rdat);
            if (v != prev) begin
                nsteps++;
                check("fade_up_step", 32'(v), 32'(prev + 1));
                if (nsteps >= 2) check("fade_up_interval", 32'(cyc - last), 32'd10);
                check("fade_up_busy", 32'(busy), (v != 5) ? 32'h1 : 32'h0);
                last = cyc; prev = v;
                if (v == 5) done = 1'b1;
            end
        end
        check("fade_up_done", 32'(prev), 32'd5);
        repeat (20) @(negedge clk); #1;
        check("fade_up_hold", bus_if.rdat, 32'd5);

        // Back to 0, then up again and redirect at 3
        do_write(7'h11, 32'h00);
        bus_if.addr = 7'h21;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus_if.rdat == 32'd0) break;
        end
        check("fade_down_done", bus_if.rdat, 32'd0);
        do_write(7'h11, 32'h05);
        bus_if.addr = 7'h21;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus_if.rdat == 32'd3) break;
        end
        check("fade_reach3", bus_if.rdat, 32'd3);
        do_write(7'h11, 32'h01);
        bus_if.addr = 7'h21;
        prev = 3; idx = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            v = int'(bus_if.rdat);
            if (v != prev) begin
                check("redirect_step", 32'(v), (idx == 0) ? 32'd2 : 32'd1);
                idx++; prev = v;
            end
        end
        check("redirect_final", 32'(v), 32'd1);
        check("redirect_nsteps", 32'(idx), 32'd2);
        check("redirect_busy", 32'(busy), 32'h0);

        // Clearing fade mode mid-fade snaps to target
        do_write(7'h12, 32'h20);
        repeat (25) @(negedge clk); #1;
        check("busy_mid_fade", 32'(busy), 32'h1);
        do_write(7'h01, 32'h104);
        @(negedge clk);
        rd_check("fade_clear_snap", 7'h22, 32'h20);
        check("fade_clear_busy", 32'(busy), 32'h0);

        // Reset mid-fade
        do_write(7'h01, 32'h304);
        do_write(7'h12, 32'h40);
        repeat (25) @(negedge clk); #1;
        check("busy_before_reset", 32'(busy), 32'h1);
`else
        // Fade feature absent
        do_write(7'h02, 32'd9);
        rd_check("rate_absent", 7'h02, 32'h0);
        do_write(7'h01, 32'h304);
        rd_check("ctrl_fade_absent", 7'h01, 32'h104);
        do_write(7'h11, 32'h05);
        rd_check("cur_eq_tgt", 7'h21, 32'h05);
        check("busy_absent", 32'(busy), 32'h0);
        do_write(7'h12, 32'h40);
`endif
        #2 reset_n = 1'b0;
        rd_check("rst_tgt2", 7'h12, 32'h0);
        rd_check("rst_cur2", 7'h22, 32'h0);
        rd_check("rst_tgt1", 7'h11, 32'h0);
        rd_check("rst_cur1", 7'h21, 32'h0);
        rd_check("rst_ctrl", 7'h01, 32'h104);
        rd_check("rst_rate", 7'h02, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_led", 32'(led_ena), 32'h0);

        // Restart from cnt=0: dim 4 gives 5 of the first 16 cycles
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        s_led = tally_led;
        wait_cyc(16);
        check("led_after_reset", 32'(tally_led - s_led), 32'd5);

        // Ignored writes
        do_write(7'h13, 32'h55);
        do_write(7'h05, 32'h55);
        do_write(7'h23, 32'h55);
        do_write(7'h00, 32'h0);
        rd_check("rd_ch3_tgt", 7'h13, 32'h0);
        rd_check("rd_unmapped", 7'h05, 32'h0);
        rd_check("rd_ch3_cur", 7'h23, 32'h0);
        @(negedge clk);
        rd_check("id_after_write", 7'h00, 32'hB00F0002);
        rd_check("ctrl_untouched", 7'h01, 32'h104);
        @(negedge clk);
        rd_check("tgt0_untouched", 7'h10, 32'h0);
        rd_check("tgt1_untouched", 7'h11, 32'h0);
        rd_check("tgt2_untouched", 7'h12, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
